tile_dispatcher: RTL and testbench
==================================

# tile_dispatcher

Work scheduler for the Fractaski manycore array. It hands out frame tiles, one index at a time, to `NUM_CORES` render cores using round-robin arbitration. It tracks which cores hold an unfinished tile and signals frame completion once every tile has been issued and retired. It sits beside the core array on the core clock and replaces the all-cores barrier with per-core demand-driven dispatch.

## Interface
Parameters:
- `NUM_CORES`, 16: number of requesting cores (2..32).
- `NUM_TILES`, 64: tiles per frame (1..4096).
- `TILE_W`, `$clog2(NUM_TILES)` (min 1): tile index width.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `i_start`  in  1  start-of-frame pulse; honoured only in IDLE.
- `i_core_req`  in  NUM_CORES  level request for a tile, one bit per core.
- `i_core_done`  in  NUM_CORES  one-cycle pulse: the core has finished its current tile.
- `o_core_grant`  out  NUM_CORES  one-hot, one-cycle grant pulse.
- `o_tile_id`  out  TILE_W  tile index; valid only in the grant cycle.
- `o_core_busy`  out  NUM_CORES  the core holds an unretired tile.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_frame_done`  out  1  one-cycle pulse when the frame is complete.

## Operation
- FSM states:
  - IDLE → DISPATCH on `i_start`.
  - DISPATCH → DRAIN once `next_tile` reaches `NUM_TILES`.
  - DRAIN → DONE when `o_core_busy == 0`.
  - DONE → IDLE after exactly one cycle.
- `i_start` outside IDLE is ignored.
- Eligible core in DISPATCH: `i_core_req` is 1, its registered busy bit is 0, and it was not granted in the previous cycle.
- Arbitration:
  - Round-robin over eligible cores.
  - Search starts at the core after the last granted core; the pointer resets to core 0.
  - The pointer advances only when a grant is issued.
- On a grant:
  - `o_core_grant[k]=1` and `o_tile_id=next_tile`.
  - The core's busy bit is set and `next_tile` increments.
  - At most one grant per cycle.
- A core must drop `i_core_req` in the cycle it sees its grant. The one-cycle exclusion makes a late drop harmless.
- `i_core_done[k]` clears `o_core_busy[k]`.
  - Any number of cores may signal done in the same cycle.
  - A done pulse on a non-busy core is ignored.
  - Done pulses are accepted in every state except IDLE.
- `next_tile` counts 0..`NUM_TILES` and is `$clog2(NUM_TILES+1)` bits wide. It never wraps; it is cleared on the IDLE→DISPATCH transition.
- If `NUM_TILES` tiles are issued while cores still hold requests, no further grants occur.

## Timing
- Reset values: all outputs 0, state IDLE, `next_tile=0`, RR pointer 0, busy bits 0.
- Request sampled at edge t → grant visible after edge t+1 (1-cycle registered latency).
- Sustained throughput is one grant per cycle when a different core is eligible each cycle.
- The same core receives at most one grant every 2 cycles, and only after its tile is retired.
- Done in cycle t → busy bit clears at t+1. The core becomes eligible for arbitration from cycle t+1, so its next grant can appear at t+2.
- The last done retires at t → DONE at t+1 with `o_frame_done=1` → IDLE at t+2.
- `i_start` at t → DISPATCH at t+1 → earliest grant at t+2.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame is abandoned and `o_frame_done` does not fire.

## Configuration
- `TILE_DISPATCH_PERF_EN` defined:
  - Adds output `o_frame_cycles` (32 bits), which holds the DISPATCH+DRAIN cycle count of the last completed frame.
  - The internal counter clears on IDLE→DISPATCH and saturates at `32'hFFFF_FFFF`.
  - `o_frame_cycles` updates in the DONE cycle and resets to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- `fractaski_pkg` holds:
  - `tile_disp_state_e` (IDLE, DISPATCH, DRAIN, DONE).
  - Default core and tile count constants.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs `req`, `ptr`.
  - Outputs one-hot `gnt`, `gnt_idx`, `valid`.
  - Purely combinational; the dispatcher registers its result.

## Test plan
- Single core, NUM_TILES=4: req held, done 3 cycles after each grant → tile ids 0,1,2,3 in order; `o_frame_done` 1 cycle after the last done.
- All 16 cores request at once after start → grants to cores 0,1,…,15 on 16 consecutive cycles with tile ids 0..15.
- Done pulse on an idle core 5 in DISPATCH → `o_core_busy` unchanged and no extra tile issued.
- Core 3 asserts done and req in the same cycle → next grant to core 3 no earlier than 2 cycles later; no double allocation.
- Reset dropped to 0 after tile 10 issued → outputs 0 immediately; new start restarts from tile 0.
- With PERF_EN, one core, NUM_TILES=2, done 4 cycles after each grant → `o_frame_cycles` equals the measured DISPATCH+DRAIN span.

Source files
------------

// File: rtl/fractaski_pkg.sv
// Shared types and defaults for the Fractaski tile dispatch logic.
// Contents: dispatcher state enum, default core/tile counts, index-width helper.
package fractaski_pkg;

    localparam int unsigned DEF_NUM_CORES = 16;
    localparam int unsigned DEF_NUM_TILES = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } tile_disp_state_e;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index where the search starts (highest priority this cycle)
//   gnt     - one-hot grant (all zero when nothing requests)
//   gnt_idx - binary index of the granted requester
//   valid   - a grant was found
module rr_arbiter
    import fractaski_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             valid
);

    // Scan N positions starting at ptr, wrapping modulo N; first hit wins.
    always_comb begin
        logic [IDX_W-1:0] k;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDX_W'((32'(ptr) + i) % N);
            if (!valid && req[k]) begin
                valid   = 1'b1;
                gnt_idx = k;
                gnt[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_dispatcher.sv
// Demand-driven tile dispatcher: issues frame tile indices one per cycle to
// requesting cores in round-robin order, tracks unretired tiles per core and
// pulses frame completion once every tile is issued and retired.
// Ports:
//   clk, reset      - core clock, asynchronous active-low reset
//   i_start         - start-of-frame pulse (honoured only while idle)
//   i_core_req      - per-core level request for a tile
//   i_core_done     - per-core one-cycle retire pulse
//   o_core_grant    - one-hot grant pulse
//   o_tile_id       - tile index, valid in the grant cycle
//   o_core_busy     - per-core "holds an unretired tile"
//   o_busy          - dispatcher not idle
//   o_frame_done    - one-cycle frame completion pulse
//   o_frame_cycles  - DISPATCH+DRAIN cycle count of the last completed frame
//                     (present only when TILE_DISPATCH_PERF_EN is defined)
module tile_dispatcher
    import fractaski_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned NUM_TILES = DEF_NUM_TILES,
    parameter int unsigned TILE_W    = idx_w(NUM_TILES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [NUM_CORES-1:0] i_core_req,
    input  logic [NUM_CORES-1:0] i_core_done,
    output logic [NUM_CORES-1:0] o_core_grant,
    output logic [TILE_W-1:0]    o_tile_id,
    output logic [NUM_CORES-1:0] o_core_busy,
    output logic                 o_busy,
    output logic                 o_frame_done
`ifdef TILE_DISPATCH_PERF_EN
    ,
    output logic [31:0]          o_frame_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(NUM_TILES + 1);
    localparam int unsigned IDX_W = idx_w(NUM_CORES);

    tile_disp_state_e state, state_nxt;

    logic [CNT_W-1:0]     next_tile;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_CORES-1:0] done_eff;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] busy_ret;
    logic [NUM_CORES-1:0] busy_nxt;
    logic [NUM_CORES-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 issue;
    logic                 tiles_left;

    // Retire pulses count everywhere except idle.
    assign done_eff = (state != IDLE) ? i_core_done : '0;

    // Busy cores and the core granted last cycle are excluded, so a late
    // request drop can never earn a second tile.
    assign eligible = (state == DISPATCH) ? (i_core_req & ~o_core_busy & ~o_core_grant) : '0;

    assign tiles_left = (next_tile != CNT_W'(NUM_TILES));

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .req     (eligible),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Busy vector after this cycle's retires, and after this cycle's grant.
    assign busy_ret = o_core_busy & ~done_eff;
    assign busy_nxt = busy_ret | (issue ? arb_gnt : '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) state_nxt = DISPATCH;
            end
            DISPATCH: begin
                if (!tiles_left) state_nxt = DRAIN;
                else             issue     = arb_valid;
            end
            DRAIN: begin
                // Uses post-retire busy so DONE follows the last retire by one cycle.
                if (busy_ret == '0) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tile counter, arbitration pointer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_tile    <= '0;
            ptr          <= '0;
            o_core_grant <= '0;
            o_tile_id    <= '0;
            o_core_busy  <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_core_grant <= issue ? arb_gnt : '0;
            o_tile_id    <= issue ? TILE_W'(next_tile) : '0;
            o_core_busy  <= busy_nxt;
            o_busy       <= (state_nxt != IDLE);
            o_frame_done <= (state_nxt == DONE);

            if (state == IDLE && i_start) begin
                next_tile <= '0;
            end else if (issue) begin
                next_tile <= next_tile + CNT_W'(1);
            end

            // Next search begins just after the core granted now.
            if (issue) begin
                ptr <= (arb_idx == IDX_W'(NUM_CORES - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
        end
    end

`ifdef TILE_DISPATCH_PERF_EN
    logic [31:0] frame_cnt, frame_cnt_nxt;

    // Saturating count of DISPATCH+DRAIN cycles, including the current one.
    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (state == IDLE && i_start) begin
            frame_cnt_nxt = '0;
        end else if ((state == DISPATCH || state == DRAIN) && frame_cnt != 32'hFFFF_FFFF) begin
            frame_cnt_nxt = frame_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt      <= '0;
            o_frame_cycles <= '0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            if (state_nxt == DONE) o_frame_cycles <= frame_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_tile_dispatcher.sv
// Self-checking bench for tile_dispatcher: directed scenarios plus randomized
// frames, compared every cycle against a frame-level behavioural model.
module tb_tile_dispatcher;

    localparam int unsigned NC = 16;
    localparam int unsigned NT = 24;
    localparam int unsigned TW = $clog2(NT);

    localparam int P_IDLE  = 0;
    localparam int P_DISP  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NC-1:0] req;
    logic [NC-1:0] done;
    logic [NC-1:0] grant;
    logic [TW-1:0] tile_id;
    logic [NC-1:0] core_busy;
    logic          busy;
    logic          frame_done;
`ifdef TILE_DISPATCH_PERF_EN
    logic [31:0]   frame_cycles;
`endif

    always #5 clk = ~clk;

    tile_dispatcher #(
        .NUM_CORES (NC),
        .NUM_TILES (NT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_core_req   (req),
        .i_core_done  (done),
        .o_core_grant (grant),
        .o_tile_id    (tile_id),
        .o_core_busy  (core_busy),
        .o_busy       (busy),
        .o_frame_done (frame_done)
`ifdef TILE_DISPATCH_PERF_EN
        ,
        .o_frame_cycles (frame_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: frame phase, tiles handed out, holders, last winner.
    int  m_phase;
    int  m_next;
    int  m_last;
    int  m_prev;
    bit  m_hold [NC];
    int  perf_cnt;

    logic [NC-1:0] e_grant;
    logic [TW-1:0] e_tile;
    logic [NC-1:0] e_holders;
    logic          e_busy;
    logic          e_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_next  = 0;
        m_last  = NC - 1;
        m_prev  = -1;
        for (int k = 0; k < NC; k++) m_hold[k] = 1'b0;
        perf_cnt  = 0;
        e_grant   = '0;
        e_tile    = '0;
        e_holders = '0;
        e_busy    = 1'b0;
        e_fd      = 1'b0;
    endfunction

    // Advance the model by one cycle using the inputs currently driven.
    function automatic void model_step();
        int  winner;
        int  issued_before;
        bit  anyone;
        winner        = -1;
        issued_before = m_next;
        if (m_phase == P_DISP && m_next < NT) begin
            for (int i = 1; i <= NC; i++) begin
                int c;
                c = (m_last + i) % NC;
                if (winner < 0 && req[c] && !m_hold[c] && m_prev != c) winner = c;
            end
        end
        if (m_phase != P_IDLE) begin
            for (int k = 0; k < NC; k++) if (done[k]) m_hold[k] = 1'b0;
        end
        e_grant = '0;
        e_tile  = '0;
        if (winner >= 0) begin
            m_hold[winner]  = 1'b1;
            e_grant[winner] = 1'b1;
            e_tile          = TW'(m_next);
            m_next          = m_next + 1;
            m_last          = winner;
        end
        m_prev = winner;
        anyone = 1'b0;
        for (int k = 0; k < NC; k++) begin
            e_holders[k] = m_hold[k];
            anyone       = anyone | m_hold[k];
        end
        case (m_phase)
            P_IDLE:  if (start) begin m_phase = P_DISP; m_next = 0; end
            P_DISP:  if (issued_before == NT) m_phase = P_DRAIN;
            P_DRAIN: if (!anyone) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
        e_busy = (m_phase != P_IDLE);
        e_fd   = (m_phase == P_DONE);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("grant", 32'(grant), 32'(e_grant));
        check("tile_id", 32'(tile_id), 32'(e_tile));
        check("core_busy", 32'(core_busy), 32'(e_holders));
        check("busy", 32'(busy), 32'(e_busy));
        check("frame_done", 32'(frame_done), 32'(e_fd));
`ifdef TILE_DISPATCH_PERF_EN
        if (e_fd) begin
            check("frame_cycles", frame_cycles, 32'(perf_cnt));
            perf_cnt = 0;
        end else if (e_busy) begin
            perf_cnt++;
        end
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_tile"}, 32'(tile_id), 0);
        check({tag, "_core_busy"}, 32'(core_busy), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        start = 1'b0;
        req   = '0;
        done  = '0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Random core behaviour: drop request when granted, retire at random.
    task automatic drive_auto(input int req_p, input int done_p);
        for (int k = 0; k < NC; k++) begin
            if (m_hold[k]) done[k] = ($urandom_range(0, 99) < done_p);
            else           done[k] = ($urandom_range(0, 99) < 3);
            req[k] = e_grant[k] ? 1'b0 : ($urandom_range(0, 99) < req_p);
        end
        start = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run_until_idle(input int req_p, input int done_p);
        int n;
        int fd;
        n  = 0;
        fd = 0;
        while (m_phase != P_IDLE && n < 3000) begin
            drive_auto(req_p, done_p);
            tick();
            if (frame_done) fd++;
            n++;
        end
        req   = '0;
        done  = '0;
        start = 1'b0;
        check("frame_timeout", 32'(n >= 3000), 0);
        check("frame_done_count", 32'(fd), 1);
    endtask

    initial begin
        int w;
        reset = 1'b0;
        start = 1'b0;
        req   = '0;
        done  = '0;
        model_reset();
        apply_reset("reset");
        tick();

        // All cores request together: strict order 0..15, tiles 0..15.
        start_frame();
        req = '1;
        for (int i = 0; i < NC; i++) begin
            tick();
            check("rr_all_grant", 32'(grant), 32'(1) << i);
            check("rr_all_tile", 32'(tile_id), 32'(i));
            req[i] = 1'b0;
        end
        run_until_idle(40, 25);

        // Retire pulse on a core that holds nothing changes nothing.
        start_frame();
        req = 16'h0001;
        tick();
        req = '0;
        tick();
        done = 16'h0020;
        tick();
        done = '0;
        check("idle_done_busy", 32'(core_busy), 32'h0001);
        check("idle_done_grant", 32'(grant), 0);

        // Retire and re-request in the same cycle: no grant the next cycle.
        req = 16'h0008;
        tick();
        check("c3_first_grant", 32'(grant), 32'h0008);
        req = '0;
        tick();
        tick();
        done = 16'h0008;
        req  = 16'h0008;
        tick();
        done = '0;
        check("c3_no_early_grant", 32'(grant), 0);
        tick();
        check("c3_regrant", 32'(grant), 32'h0008);
        check("c3_regrant_tile", 32'(tile_id), 2);
        req = '0;
        run_until_idle(40, 25);

        // Single core, retire three cycles after each grant.
        start_frame();
        for (int t = 0; t < NT; t++) begin
            req[0] = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!grant[0] && w < 10);
            check("single_grant_seen", 32'(grant[0]), 1);
            check("single_tile", 32'(tile_id), 32'(t));
            req[0] = 1'b0;
            tick();
            req[0] = 1'b1;
            tick();
            tick();
            req[0] = 1'b0;
            done[0] = 1'b1;
            tick();
            done[0] = 1'b0;
        end
        check("single_frame_done", 32'(frame_done), 1);
        tick();
        check("single_idle", 32'(busy), 0);

        // Reset mid-frame after tile 10 has gone out.
        start_frame();
        w = 0;
        while (m_next <= 10 && w < 500) begin
            drive_auto(50, 20);
            start = 1'b0;
            tick();
            w++;
        end
        check("mid_reset_reached", 32'(m_next > 10), 1);
        apply_reset("mid_reset");
        tick();
        check("mid_reset_no_done", 32'(frame_done), 0);
        start_frame();
        req = 16'h0080;
        tick();
        check("restart_grant", 32'(grant), 32'h0080);
        check("restart_tile", 32'(tile_id), 0);
        req = '0;
        run_until_idle(40, 25);

        // Randomized frames with varying demand and retire rates.
        for (int f = 0; f < 4; f++) begin
            start_frame();
            run_until_idle(20 + 20 * f, 15 + 10 * f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
